// File: rtl/wrb_pkg.sv
// Shared constants and types for the writeback arbiter slice.
// Source indices name the producing units.
// wrb_entry_t is the default-width FIFO payload, used when the top runs with
// the standard register-index and data widths.
package wrb_pkg;

  localparam int WRB_SRC_LSU      = 0;
  localparam int WRB_SRC_MD       = 1;
  localparam int WRB_SRC_FDIVSQRT = 2;
  localparam int WRB_NUM_SRC      = 3;

  localparam int WRB_NUM_WP         = 2;
  localparam int WRB_FIFO_DEPTH     = 2;
  localparam int WRB_REG_SIZE_WIDTH = 7;
  localparam int WRB_XLEN           = 64;

  typedef struct packed {
    logic [WRB_REG_SIZE_WIDTH-1:0] preg;
    logic [WRB_XLEN-1:0]           data;
  } wrb_entry_t;

  // Index of the source 'offset' positions after 'base', wrapping over n sources.
  function automatic int wrb_wrap_idx(input int base, input int offset, input int n);
    return (base + offset) % n;
  endfunction

endpackage

// File: rtl/wrb_src_fifo.sv
// Per-source result FIFO for the writeback arbiter.
// It holds in-order results from one execution unit. DEPTH must be a power of
// two, so the pointers wrap naturally. Callers never push when count == DEPTH
// and never pop when count == 0. The head is valid whenever count != 0.
module wrb_src_fifo
  import wrb_pkg::*;
#(
  parameter int  DEPTH   = WRB_FIFO_DEPTH,
  parameter type entry_t = wrb_entry_t,
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  entry_t           push_entry,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output entry_t           head
);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointer and occupancy tracking; a push and a pop together leave count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Storage has no reset, because a slot is only read after a push has filled it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/wrb_arbiter.sv
// Writeback-side producer for the physical register file.
// Each variable-latency unit (LSU, MD, FDIVSQRT) feeds its own small FIFO.
// Each cycle a round-robin scan drains up to NUM_WP heads onto registered
// regfile write ports. Writes to p0 are swallowed at the input. The FIFO
// ready depends only on registered occupancy, so no input-to-output
// combinational path exists.
module wrb_arbiter
  import wrb_pkg::*;
#(
  parameter int NUM_SRC        = WRB_NUM_SRC,
  parameter int NUM_WP         = WRB_NUM_WP,
  parameter int FIFO_DEPTH     = WRB_FIFO_DEPTH,
  parameter int REG_SIZE_WIDTH = WRB_REG_SIZE_WIDTH,
  parameter int XLEN           = WRB_XLEN
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_SRC-1:0]               src_valid_i,
  output logic [NUM_SRC-1:0]               src_ready_o,
  input  logic [NUM_SRC*REG_SIZE_WIDTH-1:0] src_address_i,
  input  logic [NUM_SRC*XLEN-1:0]          src_data_i,
  output logic [NUM_WP-1:0]                wrb_valid_o,
  output logic [NUM_WP*REG_SIZE_WIDTH-1:0] wrb_address_o,
  output logic [NUM_WP*XLEN-1:0]           wrb_data_o,
  output logic                             busy_o
);

  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam int SRC_IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  // Same layout as wrb_entry_t, but sized from this instance's parameters.
  typedef struct packed {
    logic [REG_SIZE_WIDTH-1:0] preg;
    logic [XLEN-1:0]           data;
  } entry_t;

  logic [CNT_W-1:0]     count      [NUM_SRC];
  entry_t               head       [NUM_SRC];
  entry_t               push_entry [NUM_SRC];
  logic [NUM_SRC-1:0]   push;
  logic [NUM_SRC-1:0]   grant;
  logic [NUM_SRC-1:0]   not_empty;

  logic [SRC_IDX_W-1:0] rr_ptr;
  logic [SRC_IDX_W-1:0] next_rr;
  logic [NUM_WP-1:0]    port_vld;
  logic [SRC_IDX_W-1:0] port_src   [NUM_WP];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [REG_SIZE_WIDTH-1:0] in_addr;
    logic [XLEN-1:0]           in_data;

    assign in_addr       = src_address_i[i*REG_SIZE_WIDTH +: REG_SIZE_WIDTH];
    assign in_data       = src_data_i[i*XLEN +: XLEN];
    assign push_entry[i] = {in_addr, in_data};

    assign src_ready_o[i] = (count[i] != FULL_CNT);
    assign not_empty[i]   = (count[i] != '0);
    // A p0 result completes its handshake but never occupies a FIFO slot.
    assign push[i]        = src_valid_i[i] && src_ready_o[i] && (in_addr != '0);

    wrb_src_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (entry_t)
    ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push[i]),
      .push_entry (push_entry[i]),
      .pop        (grant[i]),
      .count      (count[i]),
      .head       (head[i])
    );
  end

  // Round-robin scan from rr_ptr: the k-th non-empty source found drives write port k.
  always_comb begin
    int n_grant;
    int idx;
    int last_idx;

    grant    = '0;
    port_vld = '0;
    for (int k = 0; k < NUM_WP; k++) begin
      port_src[k] = '0;
    end
    n_grant  = 0;
    idx      = 0;
    last_idx = int'(rr_ptr);

    for (int k = 0; k < NUM_SRC; k++) begin
      idx = wrb_wrap_idx(int'(rr_ptr), k, NUM_SRC);
      if ((n_grant < NUM_WP) && not_empty[idx]) begin
        grant[idx]        = 1'b1;
        port_vld[n_grant] = 1'b1;
        port_src[n_grant] = SRC_IDX_W'(idx);
        last_idx          = idx;
        n_grant           = n_grant + 1;
      end
    end

    next_rr = SRC_IDX_W'(wrb_wrap_idx(last_idx, 1, NUM_SRC));
  end

  // The pointer moves just past the last source served, and stays put on idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (|grant) begin
      rr_ptr <= next_rr;
    end
  end

  // Write-port registers: valid pulses once per entry, and address/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrb_valid_o   <= '0;
      wrb_address_o <= '0;
      wrb_data_o    <= '0;
    end else begin
      wrb_valid_o <= port_vld;
      for (int k = 0; k < NUM_WP; k++) begin
        if (port_vld[k]) begin
          wrb_address_o[k*REG_SIZE_WIDTH +: REG_SIZE_WIDTH] <= head[port_src[k]].preg;
          wrb_data_o[k*XLEN +: XLEN]                        <= head[port_src[k]].data;
        end
      end
    end
  end

  assign busy_o = (|not_empty) || (|wrb_valid_o);

endmodule

// File: tb/tb_wrb_arbiter.sv
// Self-checking bench for wrb_arbiter.
// A stimulus process drives each cycle at the falling edge and advances a
// queue-level reference model. The model predicts each write-port beat and
// pushes it to a scoreboard. A separate monitor pops and compares the
// expectations after every rising edge.
module tb_wrb_arbiter;
  import wrb_pkg::*;

  localparam int NS    = 3;
  localparam int NW    = 2;
  localparam int DEPTH = 2;
  localparam int AW    = 7;
  localparam int DW    = 64;
  localparam int SLOTS = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NS-1:0]     src_valid_i;
  logic [NS-1:0]     src_ready_o;
  logic [NS*AW-1:0]  src_address_i;
  logic [NS*DW-1:0]  src_data_i;
  logic [NW-1:0]     wrb_valid_o;
  logic [NW*AW-1:0]  wrb_address_o;
  logic [NW*DW-1:0]  wrb_data_o;
  logic              busy_o;

  always #5 clk = ~clk;

  wrb_arbiter #(
    .NUM_SRC        (NS),
    .NUM_WP         (NW),
    .FIFO_DEPTH     (DEPTH),
    .REG_SIZE_WIDTH (AW),
    .XLEN           (DW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .src_valid_i   (src_valid_i),
    .src_ready_o   (src_ready_o),
    .src_address_i (src_address_i),
    .src_data_i    (src_data_i),
    .wrb_valid_o   (wrb_valid_o),
    .wrb_address_o (wrb_address_o),
    .wrb_data_o    (wrb_data_o),
    .busy_o        (busy_o)
  );

  int n_compared   = 0;
  int n_mismatched = 0;
  int edge_cnt     = 0;
  int last_drive_edge = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // The reference model keeps per-source queues of pending results, plus the
  // round-robin starting source.
  logic [AW-1:0] m_addr [NS][SLOTS];
  logic [DW-1:0] m_data [NS][SLOTS];
  int            m_cnt  [NS];
  int            m_rd   [NS];
  int            m_rr;
  bit            m_last_valid;

  typedef struct {
    int            edge_no;
    int            port;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];

  int fair_lo = -1;
  int fair_hi = -2;
  int fair_cnt  [NS];
  int fair_last [NS];
  int fair_max_gap = 0;

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)",
               name, actual, expected, edge_cnt);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NS; i++) begin
      m_cnt[i] = 0;
      m_rd[i]  = 0;
    end
    m_rr         = 0;
    m_last_valid = 0;
    exp_q.delete();
  endtask

  function automatic logic [DW-1:0] rand_data(input int s);
    logic [1:0] tag;
    tag = s[1:0];
    return {tag, 30'($urandom), 32'($urandom)};
  endfunction

  // One cycle: check ready/busy against the model, drive inputs, then advance the model.
  task automatic applyStimulus(input logic [NS-1:0] vld,
                               input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                               input logic [AW-1:0] a2,
                               input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                               input logic [DW-1:0] d2);
    logic [AW-1:0] a [NS];
    logic [DW-1:0] d [NS];
    bit            rdy [NS];
    bit            exp_busy;
    int            n;
    int            last;
    int            s;
    int            w;
    exp_t          e;

    a[0] = a0; a[1] = a1; a[2] = a2;
    d[0] = d0; d[1] = d1; d[2] = d2;

    @(negedge clk);
    exp_busy = m_last_valid;
    for (int i = 0; i < NS; i++) begin
      rdy[i] = (m_cnt[i] < DEPTH);
      if (m_cnt[i] != 0) exp_busy = 1'b1;
      checkOutput($sformatf("src_ready[%0d]", i), 128'(src_ready_o[i]), 128'(rdy[i]));
    end
    checkOutput("busy", 128'(busy_o), 128'(exp_busy));

    src_valid_i     = vld;
    src_address_i   = {a[2], a[1], a[0]};
    src_data_i      = {d[2], d[1], d[0]};
    last_drive_edge = edge_cnt + 1;

    n    = 0;
    last = -1;
    for (int k = 0; k < NS; k++) begin
      s = (m_rr + k) % NS;
      if (n < NW && m_cnt[s] > 0) begin
        e.edge_no = edge_cnt + 1;
        e.port    = n;
        e.addr    = m_addr[s][m_rd[s]];
        e.data    = m_data[s][m_rd[s]];
        exp_q.push_back(e);
        m_rd[s]  = (m_rd[s] + 1) % SLOTS;
        m_cnt[s] = m_cnt[s] - 1;
        n        = n + 1;
        last     = s;
      end
    end
    if (last >= 0) m_rr = (last + 1) % NS;
    m_last_valid = (n != 0);

    for (int i = 0; i < NS; i++) begin
      if (vld[i] && rdy[i] && a[i] != '0) begin
        w = (m_rd[i] + m_cnt[i]) % SLOTS;
        m_addr[i][w] = a[i];
        m_data[i][w] = d[i];
        m_cnt[i]     = m_cnt[i] + 1;
      end
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus('0, '0, '0, '0, '0, '0, '0);
  endtask

  // Scoreboard monitor: gathers this edge's expected beats and compares every port.
  logic [NW-1:0] mon_ev;
  logic [AW-1:0] mon_ea [NW];
  logic [DW-1:0] mon_ed [NW];
  exp_t          mon_e;
  int            mon_tag;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rst_n) begin
        mon_ev = '0;
        for (int k = 0; k < NW; k++) begin
          mon_ea[k] = '0;
          mon_ed[k] = '0;
        end
        while (exp_q.size() > 0 && exp_q[0].edge_no <= edge_cnt) begin
          mon_e = exp_q.pop_front();
          if (mon_e.edge_no == edge_cnt) begin
            mon_ev[mon_e.port] = 1'b1;
            mon_ea[mon_e.port] = mon_e.addr;
            mon_ed[mon_e.port] = mon_e.data;
          end else begin
            checkOutput("stale_expectation", 128'(edge_cnt), 128'(mon_e.edge_no));
          end
        end
        for (int k = 0; k < NW; k++) begin
          checkOutput($sformatf("wrb_valid[%0d]", k), 128'(wrb_valid_o[k]), 128'(mon_ev[k]));
          if (mon_ev[k]) begin
            checkOutput($sformatf("wrb_address[%0d]", k),
                        128'(wrb_address_o[k*AW +: AW]), 128'(mon_ea[k]));
            checkOutput($sformatf("wrb_data[%0d]", k),
                        128'(wrb_data_o[k*DW +: DW]), 128'(mon_ed[k]));
          end
          if (wrb_valid_o[k] && edge_cnt >= fair_lo && edge_cnt <= fair_hi) begin
            mon_tag = int'(wrb_data_o[k*DW + DW - 2 +: 2]);
            if (mon_tag < NS) begin
              fair_cnt[mon_tag]++;
              if (fair_last[mon_tag] >= 0 && edge_cnt - fair_last[mon_tag] > fair_max_gap)
                fair_max_gap = edge_cnt - fair_last[mon_tag];
              fair_last[mon_tag] = edge_cnt;
            end
          end
        end
      end
    end
  end

  // Assert reset asynchronously between edges and check the outputs clear at once.
  task automatic applyReset();
    @(posedge clk);
    #3;
    rst_n       = 1'b0;
    src_valid_i = '0;
    #1;
    checkOutput("async_rst_wrb_valid", 128'(wrb_valid_o), 128'(0));
    checkOutput("async_rst_busy", 128'(busy_o), 128'(0));
    checkOutput("async_rst_ready", 128'(src_ready_o), 128'({NS{1'b1}}));
    modelReset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    src_valid_i   = '0;
    src_address_i = '0;
    src_data_i    = '0;
    modelReset();
    for (int i = 0; i < NS; i++) begin
      fair_cnt[i]  = 0;
      fair_last[i] = -1;
    end

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("reset_wrb_valid", 128'(wrb_valid_o), 128'(0));
    checkOutput("reset_wrb_address", 128'(wrb_address_o), 128'(0));
    checkOutput("reset_wrb_data", 128'(wrb_data_o), 128'(0));
    checkOutput("reset_src_ready", 128'(src_ready_o), 128'({NS{1'b1}}));
    checkOutput("reset_busy", 128'(busy_o), 128'(0));

    $display("[TB] three sources together from rr_ptr 0");
    applyStimulus(3'b111, 7'd10, 7'd11, 7'd12,
                  64'h0000_0000_0000_0A0A, 64'h0000_0000_0000_0B0B, 64'h0000_0000_0000_0C0C);
    idleCycles(4);

    $display("[TB] single result on LSU");
    applyStimulus(3'b001 << WRB_SRC_LSU, 7'd5, '0, '0, 64'hDEAD_BEEF, '0, '0);
    idleCycles(3);

    $display("[TB] p0 write on FDIVSQRT is filtered");
    applyStimulus(3'b001 << WRB_SRC_FDIVSQRT, '0, '0, '0, '0, '0, 64'hFFFF);
    idleCycles(3);

    $display("[TB] saturation: fairness and backpressure");
    for (int c = 0; c < 32; c++) begin
      applyStimulus(3'b111, 7'($urandom_range(1, 127)), 7'($urandom_range(1, 127)),
                    7'($urandom_range(1, 127)), rand_data(0), rand_data(1), rand_data(2));
      if (c == 0) begin
        fair_lo = last_drive_edge + 1;
        fair_hi = last_drive_edge + 30;
      end
    end
    idleCycles(6);

    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++) begin
      logic [AW-1:0] ra [NS];
      for (int i = 0; i < NS; i++)
        ra[i] = ($urandom_range(0, 7) == 0) ? '0 : 7'($urandom_range(1, 127));
      applyStimulus(3'($urandom_range(0, 7)), ra[0], ra[1], ra[2],
                    rand_data(0), rand_data(1), rand_data(2));
    end
    idleCycles(6);

    $display("[TB] async reset with entries queued");
    applyStimulus(3'b111, 7'd20, 7'd21, 7'd22, 64'h20, 64'h21, 64'h22);
    applyStimulus(3'b011, 7'd23, 7'd24, '0, 64'h23, 64'h24, '0);
    applyReset();
    idleCycles(6);

    checkOutput("exp_q_drained", 128'(exp_q.size()), 128'(0));
    for (int i = 0; i < NS; i++) begin
      checkOutput($sformatf("fair_cnt_in_range[%0d]", i),
                  128'(fair_cnt[i] >= 19 && fair_cnt[i] <= 21), 128'(1));
    end
    checkOutput("fair_max_gap_le_2", 128'(fair_max_gap <= 2 && fair_max_gap > 0), 128'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
